// File: rtl/sweep_pkg.sv
// sweep_pkg: shared FSM states, counter direction encoding and default widths
package sweep_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, DONE} state_t;
  localparam logic CNT_UP = 1'b0;
  localparam logic CNT_DN = 1'b1;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_SWEEP_W = 8;
endpackage

// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: ping-pongs an external up/down counter between latched limits
// Ports: clk/rst_n (async active-low); start/abort commands; lo_lim/hi_lim/num_sweeps run setup;
// count_in counter readback; load_en/load_val/upcount_en counter drive; busy/done/err/sweep_cnt status.
module updown_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SWEEP_W = DEF_SWEEP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   lo_lim,
  input  logic [WIDTH-1:0]   hi_lim,
  input  logic [SWEEP_W-1:0] num_sweeps,
  input  logic [WIDTH-1:0]   count_in,
  output logic               load_en,
  output logic [WIDTH-1:0]   load_val,
  output logic               upcount_en,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SWEEP_W-1:0] sweep_cnt
);
  state_t             r_state;
  logic [WIDTH-1:0]   r_lo, r_hi;
  logic [SWEEP_W-1:0] r_num, r_sweep_cnt;
  logic               r_done, r_err;
  logic               w_at_lo, w_at_hi, w_last;
  logic [SWEEP_W-1:0] w_next_cnt;

  assign w_at_lo    = count_in == r_lo;
  assign w_at_hi    = count_in == r_hi;
  assign w_next_cnt = r_sweep_cnt + 1'b1;
  assign w_last     = w_next_cnt == r_num;
  assign busy       = r_state inside {LOAD, UP, DOWN};
  assign done       = r_done;
  assign err        = r_err;
  assign sweep_cnt  = r_sweep_cnt;

  // The counter moves every cycle, so holding means reloading its own value.
  always_comb begin
    load_en    = 1'b1;
    load_val   = count_in;
    upcount_en = CNT_UP;
    case (r_state)
      LOAD: load_val = r_lo;
      UP: begin
        load_en    = 1'b0;
        upcount_en = w_at_hi ? CNT_DN : CNT_UP;
      end
      DOWN: begin
        load_en    = w_at_lo && w_last;
        load_val   = r_lo;
        upcount_en = w_at_lo ? CNT_UP : CNT_DN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_lo        <= '0;
      r_hi        <= '0;
      r_num       <= '0;
      r_sweep_cnt <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) r_state <= IDLE;
      else case (r_state)
        IDLE: if (start) begin
          if (lo_lim >= hi_lim) begin
            r_err  <= 1'b1;
            r_done <= 1'b1;
          end else begin
            r_err       <= 1'b0;
            r_sweep_cnt <= '0;
            r_lo        <= lo_lim;
            r_hi        <= hi_lim;
            r_num       <= num_sweeps;
            r_state     <= LOAD;
          end
        end
        LOAD: begin
          r_state <= (r_num == '0) ? DONE : UP;
          r_done  <= r_num == '0;
        end
        UP: if (w_at_hi) r_state <= DOWN;
        DOWN: if (w_at_lo) begin
          r_sweep_cnt <= w_next_cnt;
          r_state     <= w_last ? DONE : UP;
          r_done      <= w_last;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb_updown_sweep_ctrl: drives the sweep controller against a plain up/down counter and an expected-sequence model
module tb_updown_sweep_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] lo_lim = '0, hi_lim = '0;
  logic [7:0] num_sweeps = '0;
  logic [3:0] cnt = 4'd0;
  logic       load_en, upcount_en, busy, done, err;
  logic [3:0] load_val;
  logic [7:0] sweep_cnt;
  int checks = 0;
  int failures = 0;

  updown_sweep_ctrl #(.WIDTH(4), .SWEEP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .num_sweeps(num_sweeps), .count_in(cnt),
    .load_en(load_en), .load_val(load_val), .upcount_en(upcount_en),
    .busy(busy), .done(done), .err(err), .sweep_cnt(sweep_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in for the controlled counter: load wins, else 0 = up, 1 = down; no reset of its own.
  always @(posedge clk) cnt <= load_en ? load_val : (upcount_en ? cnt - 4'd1 : cnt + 4'd1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected trajectory: lo, then (lo+1..hi, hi-1..lo) per sweep; done one cycle after the final lo.
  task automatic run(input int lo, input int hi, input int n);
    int q[$];
    bit last;
    lo_lim = 4'(lo); hi_lim = 4'(hi); num_sweeps = 8'(n); start = 1'b1;
    step();
    start = 1'b0;
    chk("load_busy", 32'(busy), 1);
    chk("load_en", 32'(load_en), 1);
    chk("load_val", 32'(load_val), 32'(lo));
    q.push_back(lo);
    for (int s = 0; s < n; s++) begin
      for (int v = lo + 1; v <= hi; v++) q.push_back(v);
      for (int v = hi - 1; v >= lo; v--) q.push_back(v);
    end
    foreach (q[i]) begin
      lo_lim = 4'($urandom); hi_lim = 4'($urandom); num_sweeps = 8'($urandom);
      start = 1'($urandom_range(0, 1));
      step();
      last = (n == 0) && (i == q.size() - 1);
      chk("count", 32'(cnt), 32'(q[i]));
      chk("done_run", 32'(done), 32'(last));
      chk("busy_run", 32'(busy), 32'(!last));
    end
    start = 1'b0;
    if (n > 0) begin
      step();
      chk("done", 32'(done), 1);
      chk("count_end", 32'(cnt), 32'(lo));
      chk("busy_done", 32'(busy), 0);
    end
    step();
    chk("done_clr", 32'(done), 0);
    chk("count_hold", 32'(cnt), 32'(lo));
    chk("busy_idle", 32'(busy), 0);
    chk("sweeps", 32'(sweep_cnt), 32'(n));
    chk("err_ok", 32'(err), 0);
  endtask

  task automatic err_case(input int lo, input int hi);
    logic [3:0] prev;
    prev = cnt;
    lo_lim = 4'(lo); hi_lim = 4'(hi); num_sweeps = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    chk("err_set", 32'(err), 1);
    chk("err_done", 32'(done), 1);
    chk("err_busy", 32'(busy), 0);
    chk("err_hold", 32'(cnt), 32'(prev));
    step();
    chk("err_done_clr", 32'(done), 0);
    chk("err_sticky", 32'(err), 1);
    chk("err_busy2", 32'(busy), 0);
    chk("err_hold2", 32'(cnt), 32'(prev));
  endtask

  initial begin
    int lo, hi;
    logic [3:0] snap;
    #1;
    chk("rst_load_en", 32'(load_en), 1);
    chk("rst_load_val", 32'(load_val), 32'(cnt));
    chk("rst_upcount", 32'(upcount_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_sweeps", 32'(sweep_cnt), 0);
    step();
    rst_n = 1'b1;
    step();
    run(2, 5, 1);
    run(0, 15, 2);
    err_case(7, 7);
    err_case(9, 3);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", 32'(busy), 0);
    chk("abort_start_done", 32'(done), 0);
    chk("abort_start_err", 32'(err), 1);
    run(4, 8, 0);
    lo_lim = 4'd1; hi_lim = 4'd10; num_sweeps = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 20 && cnt != 4'd6; k++) step();
    chk("abort_reach", 32'(cnt), 6);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_cnt", 32'(cnt), 7);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    step();
    chk("abort_hold", 32'(cnt), 7);
    chk("abort_done2", 32'(done), 0);
    chk("abort_sweeps", 32'(sweep_cnt), 0);
    run(1, 10, 1);
    for (int r = 0; r < 12; r++) begin
      lo = $urandom_range(0, 14);
      hi = $urandom_range(15, lo + 1);
      if (r % 4 == 3) err_case(hi, $urandom_range(hi, 0));
      else run(lo, hi, $urandom_range(0, 3));
    end
    lo_lim = 4'd3; hi_lim = 4'd12; num_sweeps = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 31; k++) step();
    chk("pre_rst_sweeps", 32'(sweep_cnt), 1);
    chk("pre_rst_dir", 32'(upcount_en), 1);
    chk("pre_rst_busy", 32'(busy), 1);
    snap = cnt;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_load_en", 32'(load_en), 1);
    chk("arst_load_val", 32'(load_val), 32'(snap));
    chk("arst_upcount", 32'(upcount_en), 0);
    chk("arst_sweeps", 32'(sweep_cnt), 0);
    lo_lim = 4'd2; hi_lim = 4'd9; num_sweeps = 8'd1; start = 1'b1;
    step();
    chk("rst_start_busy", 32'(busy), 0);
    chk("rst_start_cnt", 32'(cnt), 32'(snap));
    start = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_cnt", 32'(cnt), 32'(snap));
    run(2, 9, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
